// File: rtl/exu2ifu.sv
// exu2ifu: EXU->IFU redirect return stage, a 2-entry fully registered skid buffer.
// Build macro EXU2IFU_LAST_WINS_EN: EXU is never stalled; a full buffer overwrites its newest entry.
module exu2ifu #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] ADDR_INIT = 32'h8000_0000
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic              i_sys_flush,
    input  logic              i_exu_valid,
    output logic              o_exu_ready,
    input  logic [ADDR_W-1:0] i_exu_pc,
    input  logic [ADDR_W-1:0] i_exu_pc_jump,
    output logic              o_ifu_valid,
    input  logic              i_ifu_ready,
    output logic [ADDR_W-1:0] o_ifu_pc,
    output logic [ADDR_W-1:0] o_ifu_pc_jump,
    output logic [1:0]        o_sys_count,
    output logic              o_sys_drop
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic [ADDR_W-1:0] head_jump_q, head_jump_d;
    logic [ADDR_W-1:0] tail_pc_q, tail_pc_d;
    logic [ADDR_W-1:0] tail_jump_q, tail_jump_d;
    logic              valid_q, valid_d;
    logic [1:0]        count_q, count_d;
    logic              push;
    logic              pop;

`ifdef EXU2IFU_LAST_WINS_EN
    logic drop_q, drop_d;
    assign o_exu_ready = 1'b1;
    assign o_sys_drop  = drop_q;
`else
    logic ready_q, ready_d;
    assign o_exu_ready = ready_q;
    assign o_sys_drop  = 1'b0;
`endif

    assign push          = i_exu_valid & o_exu_ready;
    assign pop           = valid_q & i_ifu_ready;
    assign o_ifu_valid   = valid_q;
    assign o_ifu_pc      = head_pc_q;
    assign o_ifu_pc_jump = head_jump_q;
    assign o_sys_count   = count_q;

    always_comb begin
        state_d     = state_q;
        head_pc_d   = head_pc_q;
        head_jump_d = head_jump_q;
        tail_pc_d   = tail_pc_q;
        tail_jump_d = tail_jump_q;
`ifdef EXU2IFU_LAST_WINS_EN
        drop_d      = 1'b0;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d     = ST_ONE;
                    head_pc_d   = i_exu_pc;
                    head_jump_d = i_exu_pc_jump;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_pc_d   = i_exu_pc;
                    head_jump_d = i_exu_pc_jump;
                end else if (push) begin
                    state_d     = ST_TWO;
                    tail_pc_d   = i_exu_pc;
                    tail_jump_d = i_exu_pc_jump;
                end else if (pop) begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_TWO: begin
`ifdef EXU2IFU_LAST_WINS_EN
                if (push && pop) begin
                    head_pc_d   = tail_pc_q;
                    head_jump_d = tail_jump_q;
                    tail_pc_d   = i_exu_pc;
                    tail_jump_d = i_exu_pc_jump;
                end else if (push) begin
                    // Newest redirect supersedes the buffered one; the head stays intact.
                    tail_pc_d   = i_exu_pc;
                    tail_jump_d = i_exu_pc_jump;
                    drop_d      = 1'b1;
                end else if (pop) begin
                    state_d     = ST_ONE;
                    head_pc_d   = tail_pc_q;
                    head_jump_d = tail_jump_q;
                end
`else
                if (pop) begin
                    state_d     = ST_ONE;
                    head_pc_d   = tail_pc_q;
                    head_jump_d = tail_jump_q;
                end
`endif
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush only clears occupancy; payload registers keep their contents.
        if (i_sys_flush) begin
            state_d     = ST_EMPTY;
            head_pc_d   = head_pc_q;
            head_jump_d = head_jump_q;
            tail_pc_d   = tail_pc_q;
            tail_jump_d = tail_jump_q;
`ifdef EXU2IFU_LAST_WINS_EN
            drop_d      = 1'b0;
`endif
        end

        valid_d = (state_d != ST_EMPTY);
        count_d = state_d;
`ifndef EXU2IFU_LAST_WINS_EN
        ready_d = (state_d != ST_TWO);
`endif
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q     <= ST_EMPTY;
            head_pc_q   <= ADDR_INIT;
            head_jump_q <= ADDR_INIT;
            tail_pc_q   <= ADDR_INIT;
            tail_jump_q <= ADDR_INIT;
            valid_q     <= 1'b0;
            count_q     <= 2'd0;
`ifdef EXU2IFU_LAST_WINS_EN
            drop_q      <= 1'b0;
`else
            ready_q     <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            head_pc_q   <= head_pc_d;
            head_jump_q <= head_jump_d;
            tail_pc_q   <= tail_pc_d;
            tail_jump_q <= tail_jump_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
`ifdef EXU2IFU_LAST_WINS_EN
            drop_q      <= drop_d;
`else
            ready_q     <= ready_d;
`endif
        end
    end

endmodule

// File: tb/tb_exu2ifu.sv
// Bench for exu2ifu: directed scenarios plus random traffic against a queue-based redirect model.
module tb_exu2ifu;

    localparam logic [31:0] INIT = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] jp;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        exu_valid = 1'b0;
    logic        exu_ready;
    logic [31:0] exu_pc = '0;
    logic [31:0] exu_jp = '0;
    logic        ifu_valid;
    logic        ifu_ready = 1'b0;
    logic [31:0] ifu_pc;
    logic [31:0] ifu_jp;
    logic [1:0]  count;
    logic        drop;

    int checks = 0;
    int errors = 0;

    item_t q[$];
    item_t m_out;
    logic  m_drop;
    int    delivered;

    always #5 clk = ~clk;

    exu2ifu dut (
        .i_sys_clk     (clk),
        .i_sys_rst_n   (rst_n),
        .i_sys_flush   (flush),
        .i_exu_valid   (exu_valid),
        .o_exu_ready   (exu_ready),
        .i_exu_pc      (exu_pc),
        .i_exu_pc_jump (exu_jp),
        .o_ifu_valid   (ifu_valid),
        .i_ifu_ready   (ifu_ready),
        .o_ifu_pc      (ifu_pc),
        .o_ifu_pc_jump (ifu_jp),
        .o_sys_count   (count),
        .o_sys_drop    (drop)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready();
`ifdef EXU2IFU_LAST_WINS_EN
        return 1'b1;
`else
        return (q.size() < 2);
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 64'(ifu_valid), 64'(q.size() != 0));
        chk({tag, "_ready"}, 64'(exu_ready), 64'(model_ready()));
        chk({tag, "_count"}, 64'(count), 64'(q.size()));
        chk({tag, "_drop"},  64'(drop), 64'(m_drop));
        chk({tag, "_pc"},    64'(ifu_pc), 64'(m_out.pc));
        chk({tag, "_jump"},  64'(ifu_jp), 64'(m_out.jp));
    endtask

    // One clock: drive at negedge, predict transfers from the model, compare #1 after the edge.
    task automatic step(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] jp, input logic rdy, input logic fl);
        logic  do_push, do_pop;
        item_t it;
        @(negedge clk);
        exu_valid = v;
        exu_pc    = pc;
        exu_jp    = jp;
        ifu_ready = rdy;
        flush     = fl;
        do_push = v && model_ready();
        do_pop  = (q.size() != 0) && rdy;
        it.pc = pc;
        it.jp = jp;
        @(posedge clk);
        #1;
        m_drop = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                delivered++;
            end
            if (do_push) begin
                if (q.size() == 2) begin
                    q[1]   = it;
                    m_drop = 1'b1;
                end else begin
                    q.push_back(it);
                end
            end
        end
        if (q.size() != 0) m_out = q[0];
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        q.delete();
        m_out.pc = INIT;
        m_out.jp = INIT;
        m_drop   = 1'b0;
        check_all(tag);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        exu_valid = 1'b0;
        ifu_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        m_out.pc  = INIT;
        m_out.jp  = INIT;
        m_drop    = 1'b0;
        delivered = 0;

        // Reset held, then released
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ifu_valid), 64'(0));
        chk("rst_ready", 64'(exu_ready), 64'(1));
        chk("rst_pc",    64'(ifu_pc), 64'(INIT));
        chk("rst_jump",  64'(ifu_jp), 64'(INIT));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_drop",  64'(drop), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step("idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Single redirect with IFU ready
        step("t2_push", 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b1, 1'b0);
        chk("t2_valid1", 64'(ifu_valid), 64'(1));
        chk("t2_pcval",  64'(ifu_pc), 64'(32'h8000_0010));
        chk("t2_jpval",  64'(ifu_jp), 64'(32'h8000_0100));
        chk("t2_cnt1",   64'(count), 64'(1));
        step("t2_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("t2_cnt0",   64'(count), 64'(0));

        // IFU stalled: A, B fill the buffer, C attempted
        step("t3_a", 1'b1, 32'h0000_0A00, 32'h0000_0AAA, 1'b0, 1'b0);
        step("t3_b", 1'b1, 32'h0000_0B00, 32'h0000_0BBB, 1'b0, 1'b0);
        chk("t3_cnt2", 64'(count), 64'(2));
`ifndef EXU2IFU_LAST_WINS_EN
        chk("t3_nrdy", 64'(exu_ready), 64'(0));
        step("t3_c", 1'b1, 32'h0000_0C00, 32'h0000_0CCC, 1'b0, 1'b0);
        chk("t3_hold", 64'(ifu_pc), 64'(32'h0000_0A00));
        step("t3_popa", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("t3_seeb", 64'(ifu_pc), 64'(32'h0000_0B00));
`endif
        step("t3_drain1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("t3_drain2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with a full buffer and a simultaneous push
        step("t4_a", 1'b1, 32'h0000_1110, 32'h0000_1111, 1'b0, 1'b0);
        step("t4_b", 1'b1, 32'h0000_2220, 32'h0000_2222, 1'b0, 1'b0);
        step("t4_flush", 1'b1, 32'h0000_3330, 32'h0000_3333, 1'b1, 1'b1);
        chk("t4_cnt0",  64'(count), 64'(0));
        chk("t4_vld0",  64'(ifu_valid), 64'(0));
        chk("t4_phold", 64'(ifu_pc), 64'(32'h0000_1110));
        step("t4_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // One entry resident, then 20 back-to-back redirects with IFU ready
        step("t5_seed", 1'b1, 32'h0000_5000, 32'h0000_5001, 1'b0, 1'b0);
        delivered = 0;
        for (int i = 0; i < 20; i++) begin
            step("t5_b2b", 1'b1, 32'h0000_6000 + 32'(i * 4), 32'h0000_7000 + 32'(i), 1'b1, 1'b0);
            chk("t5_nobubble", 64'(ifu_valid), 64'(1));
        end
        step("t5_tail", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("t5_delivered", 64'(delivered), 64'(21));
        chk("t5_lastpc", 64'(ifu_pc), 64'(32'h0000_6000 + 32'(19 * 4)));

`ifdef EXU2IFU_LAST_WINS_EN
        // Last-wins: A, B, C with IFU stalled; C overwrites B
        step("t6_a", 1'b1, 32'h0000_A000, 32'h0000_A001, 1'b0, 1'b0);
        step("t6_b", 1'b1, 32'h0000_B000, 32'h0000_B001, 1'b0, 1'b0);
        step("t6_c", 1'b1, 32'h0000_C000, 32'h0000_C001, 1'b0, 1'b0);
        chk("t6_drop1", 64'(drop), 64'(1));
        chk("t6_rdy",   64'(exu_ready), 64'(1));
        step("t6_popa", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("t6_drop0", 64'(drop), 64'(0));
        chk("t6_seec",  64'(ifu_pc), 64'(32'h0000_C000));
        step("t6_popc", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`endif

        // Random traffic with occasional flush, then a reset mid-transfer
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            step("rnd", r[0] | r[1], $urandom, $urandom, r[2] & ~r[3], (r[7:4] == 4'hF));
        end
        step("pre_rst", 1'b1, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0, 1'b0);
        do_reset("mid_rst");
        for (int i = 0; i < 100; i++) begin
            r = $urandom;
            step("rnd2", r[0], $urandom, $urandom, r[1] | r[2], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
